// File: rtl/cacheline_adapter_pkg.sv
// cacheline_adapter_types
//   Shared types and constants for the cacheline adapter and its beat
//   assembler: FSM state encoding, burst geometry and the beat counter type.
//   line_align() clears the byte-offset bits of a line address.
//   Optional feature macro used by the design: CACHELINE_ADAPTER_WBUF_EN.
package cacheline_adapter_types;

   localparam int ADDR_W     = 32;
   localparam int BEATS      = 4;
   localparam int BEAT_W     = 64;
   localparam int LINE_W     = BEATS * BEAT_W;
   localparam int OFFSET_IDX = 5;

   typedef logic [1:0] beat_cnt_t;

   typedef enum logic [2:0] {
      IDLE,
      RD_ISSUE,
      RD_WAIT,
      RD_RESP,
      WR_BEAT
   } adapter_state_t;

   function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:OFFSET_IDX], {OFFSET_IDX{1'b0}}};
   endfunction

endpackage

// File: rtl/cacheline_adapter_beat_assembler.sv
// cacheline_beat_assembler
//   Beat counter plus one line register. Read bursts store each returned
//   beat into the slot selected by the counter; write bursts load the whole
//   line and present the slot selected by the counter as the outgoing beat.
// Ports:
//   clk, rst        clock, synchronous active-low reset (counter only)
//   i_cnt_clr       force counter to 0
//   i_cnt_inc       advance counter (wraps 3 -> 0)
//   i_line_load     load the whole line from i_line_data
//   i_line_data     line to load
//   i_beat_store    write i_beat_data into slot o_cnt
//   i_beat_data     beat to store
//   o_cnt           current beat index
//   o_last          counter is on the final beat
//   o_line          assembled / loaded line
//   o_beat          line slice selected by the counter
module cacheline_beat_assembler
   import cacheline_adapter_types::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_cnt_clr,
   input  logic              i_cnt_inc,
   input  logic              i_line_load,
   input  logic [LINE_W-1:0] i_line_data,
   input  logic              i_beat_store,
   input  logic [BEAT_W-1:0] i_beat_data,
   output beat_cnt_t         o_cnt,
   output logic              o_last,
   output logic [LINE_W-1:0] o_line,
   output logic [BEAT_W-1:0] o_beat
);

   beat_cnt_t         r_cnt;
   logic [LINE_W-1:0] r_line;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_cnt_clr) begin
         r_cnt <= '0;
      end else if (i_cnt_inc) begin
         r_cnt <= r_cnt + 2'd1;
      end
   end

   // Line storage carries no reset; its contents are only observed after a
   // complete load or a full set of beat stores.
   always_ff @(posedge clk) begin
      if (i_line_load) begin
         r_line <= i_line_data;
      end else if (i_beat_store) begin
         r_line[r_cnt*BEAT_W +: BEAT_W] <= i_beat_data;
      end
   end

   assign o_cnt  = r_cnt;
   assign o_last = (r_cnt == 2'd3);
   assign o_line = r_line;
   assign o_beat = r_line[r_cnt*BEAT_W +: BEAT_W];

endmodule

// File: rtl/cacheline_adapter.sv
// cacheline_adapter
//   Memory-side responder for the cacheline interface. Each 256-bit line
//   read or write from the cache arbiter becomes a 4-beat, 64-bit burst on
//   bmem. One request is in flight at a time.
// Optional feature: define CACHELINE_ADAPTER_WBUF_EN for a one-line posted
//   write buffer drained in the background; reads that hit the buffered
//   line are answered from it without bmem traffic. Undefined = writes
//   block the adapter until all four beats are accepted.
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   ufp_addr/read/write/wdata     request side from the cache arbiter
//   ufp_ready                     request accepted when ready & (read|write)
//   ufp_raddr/rdata/rvalid        one-cycle read response
//   bmem_addr/read/write/wdata    burst command and write beats
//   bmem_ready                    bmem accepts command or beat
//   bmem_raddr/rdata/rvalid       returned read beats
module cacheline_adapter
   import cacheline_adapter_types::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] ufp_addr,
   input  logic              ufp_read,
   input  logic              ufp_write,
   input  logic [LINE_W-1:0] ufp_wdata,
   output logic              ufp_ready,
   output logic [ADDR_W-1:0] ufp_raddr,
   output logic [LINE_W-1:0] ufp_rdata,
   output logic              ufp_rvalid,
   output logic [ADDR_W-1:0] bmem_addr,
   output logic              bmem_read,
   output logic              bmem_write,
   output logic [BEAT_W-1:0] bmem_wdata,
   input  logic              bmem_ready,
   input  logic [ADDR_W-1:0] bmem_raddr,
   input  logic [BEAT_W-1:0] bmem_rdata,
   input  logic              bmem_rvalid
);

   adapter_state_t    r_state;
   adapter_state_t    w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] w_line_addr;

   beat_cnt_t         w_cnt;
   logic              w_last;
   logic [LINE_W-1:0] w_line;
   logic [BEAT_W-1:0] w_beat;

   logic              w_cnt_clr;
   logic              w_cnt_inc;
   logic              w_line_load;
   logic [LINE_W-1:0] w_line_src;
   logic              w_beat_store;
   logic              w_addr_latch;
   logic              w_ready;
   logic              w_rvalid;
   logic              w_fsm_read;
   logic              w_fsm_write;
   logic              w_beat_match;

   logic              w_wb_valid;
   logic              w_wb_hit;
   logic [ADDR_W-1:0] w_wb_addr;
   logic [LINE_W-1:0] w_wb_data;
   logic [BEAT_W-1:0] w_wb_beat;
   logic              w_drain_write;

   assign w_line_addr  = line_align(r_addr);
   assign w_beat_match = bmem_rvalid && (bmem_raddr == w_line_addr);

   cacheline_beat_assembler u_asm (
      .clk          (clk),
      .rst          (rst),
      .i_cnt_clr    (w_cnt_clr),
      .i_cnt_inc    (w_cnt_inc),
      .i_line_load  (w_line_load),
      .i_line_data  (w_line_src),
      .i_beat_store (w_beat_store),
      .i_beat_data  (bmem_rdata),
      .o_cnt        (w_cnt),
      .o_last       (w_last),
      .o_line       (w_line),
      .o_beat       (w_beat)
   );

`ifdef CACHELINE_ADAPTER_WBUF_EN
   logic              r_wb_valid;
   logic [ADDR_W-1:0] r_wb_addr;
   logic [LINE_W-1:0] r_wb_data;
   beat_cnt_t         r_wb_cnt;
   logic              w_wb_load;

   // Drain engine: whenever the buffer holds a line it offers beats to
   // bmem; the buffer frees itself when the fourth beat is accepted.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wb_valid <= 1'b0;
         r_wb_cnt   <= '0;
      end else if (w_wb_load) begin
         r_wb_valid <= 1'b1;
         r_wb_cnt   <= '0;
      end else if (r_wb_valid && bmem_ready) begin
         r_wb_cnt <= r_wb_cnt + 2'd1;
         if (r_wb_cnt == 2'd3) begin
            r_wb_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wb_load) begin
         r_wb_addr <= line_align(ufp_addr);
         r_wb_data <= ufp_wdata;
      end
   end

   assign w_wb_valid    = r_wb_valid;
   assign w_wb_hit      = r_wb_valid && (r_wb_addr == w_line_addr);
   assign w_wb_addr     = r_wb_addr;
   assign w_wb_data     = r_wb_data;
   assign w_wb_beat     = r_wb_data[r_wb_cnt*BEAT_W +: BEAT_W];
   assign w_drain_write = r_wb_valid;
`else
   assign w_wb_valid    = 1'b0;
   assign w_wb_hit      = 1'b0;
   assign w_wb_addr     = '0;
   assign w_wb_data     = '0;
   assign w_wb_beat     = '0;
   assign w_drain_write = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_addr_latch) begin
         r_addr <= ufp_addr;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_clr    = 1'b0;
      w_cnt_inc    = 1'b0;
      w_line_load  = 1'b0;
      w_line_src   = ufp_wdata;
      w_beat_store = 1'b0;
      w_addr_latch = 1'b0;
      w_ready      = 1'b0;
      w_rvalid     = 1'b0;
      w_fsm_read   = 1'b0;
      w_fsm_write  = 1'b0;
`ifdef CACHELINE_ADAPTER_WBUF_EN
      w_wb_load    = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            // A write presented while the buffer is still draining must not
            // be accepted; reads stay acceptable in that case.
            w_ready = !(ufp_write && w_wb_valid);
            if (ufp_write && w_ready) begin
`ifdef CACHELINE_ADAPTER_WBUF_EN
               w_wb_load = 1'b1;
`else
               w_addr_latch = 1'b1;
               w_line_load  = 1'b1;
               w_cnt_clr    = 1'b1;
               w_state_nxt  = WR_BEAT;
`endif
            end else if (ufp_read && w_ready) begin
               w_addr_latch = 1'b1;
               w_state_nxt  = RD_ISSUE;
            end
         end
         RD_ISSUE: begin
            if (w_wb_hit) begin
               w_line_load = 1'b1;
               w_line_src  = w_wb_data;
               w_state_nxt = RD_RESP;
            end else begin
               // A pending buffer drain owns bmem; the read waits for it.
               w_fsm_read = !w_wb_valid;
               if (!w_wb_valid && bmem_ready) begin
                  w_cnt_clr   = 1'b1;
                  w_state_nxt = RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            if (w_beat_match) begin
               w_beat_store = 1'b1;
               w_cnt_inc    = 1'b1;
               if (w_last) begin
                  w_state_nxt = RD_RESP;
               end
            end
         end
         RD_RESP: begin
            w_rvalid    = 1'b1;
            w_state_nxt = IDLE;
         end
         WR_BEAT: begin
            w_fsm_write = 1'b1;
            if (bmem_ready) begin
               w_cnt_inc = 1'b1;
               if (w_last) begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Strobes are forced low while reset is held so nothing leaks out of a
   // burst that is being abandoned.
   assign ufp_ready  = rst && w_ready;
   assign ufp_rvalid = rst && w_rvalid;
   assign bmem_read  = rst && w_fsm_read;
   assign bmem_write = rst && (w_fsm_write || w_drain_write);
   assign bmem_addr  = w_drain_write ? w_wb_addr : w_line_addr;
   assign bmem_wdata = w_drain_write ? w_wb_beat : w_beat;
   assign ufp_raddr  = r_addr;
   assign ufp_rdata  = w_line;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed testbench for cacheline_adapter. Inputs are driven 2 time units
// after each rising edge and outputs sampled 1 unit later.
module tb_cacheline_adapter;

   logic         clk;
   logic         rst;
   logic [31:0]  ufp_addr;
   logic         ufp_read;
   logic         ufp_write;
   logic [255:0] ufp_wdata;
   logic         ufp_ready;
   logic [31:0]  ufp_raddr;
   logic [255:0] ufp_rdata;
   logic         ufp_rvalid;
   logic [31:0]  bmem_addr;
   logic         bmem_read;
   logic         bmem_write;
   logic [63:0]  bmem_wdata;
   logic         bmem_ready;
   logic [31:0]  bmem_raddr;
   logic [63:0]  bmem_rdata;
   logic         bmem_rvalid;

   int n_checks = 0;
   int n_fail   = 0;

   cacheline_adapter dut (
      .clk         (clk),
      .rst         (rst),
      .ufp_addr    (ufp_addr),
      .ufp_read    (ufp_read),
      .ufp_write   (ufp_write),
      .ufp_wdata   (ufp_wdata),
      .ufp_ready   (ufp_ready),
      .ufp_raddr   (ufp_raddr),
      .ufp_rdata   (ufp_rdata),
      .ufp_rvalid  (ufp_rvalid),
      .bmem_addr   (bmem_addr),
      .bmem_read   (bmem_read),
      .bmem_write  (bmem_write),
      .bmem_wdata  (bmem_wdata),
      .bmem_ready  (bmem_ready),
      .bmem_raddr  (bmem_raddr),
      .bmem_rdata  (bmem_rdata),
      .bmem_rvalid (bmem_rvalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   // Beat i of a test line: 0x1111.., 0x2222.., ... xor a per-test base.
   function automatic logic [63:0] mk_beat(input int i, input logic [63:0] base);
      logic [3:0] n;
      n = 4'(i + 1);
      return {16{n}} ^ base;
   endfunction

   // Present a read and wait (bounded) until it is accepted.
   task automatic rd_accept(input logic [31:0] a, input string tag);
      bit acc;
      int n;
      acc = 1'b0;
      n = 0;
      ufp_addr = a;
      ufp_read = 1'b1;
      while (!acc && n < 40) begin
         #1;
         acc = ufp_ready;
         cyc();
         n++;
      end
      ufp_read = 1'b0;
      if (!acc) check_eq({tag, "_accept_timeout"}, 256'(acc), 256'(1));
   endtask

   // Serve an accepted read: command handshake, beats, response.
   task automatic rd_complete(input logic [31:0] a, input logic [63:0] base,
                              input bit stray, input string tag);
      logic [255:0] exp;
      int bi;
      for (int i = 0; i < 4; i++) exp[64*i +: 64] = mk_beat(i, base);
      #1;
      check_eq({tag, "_bmem_read"}, 256'(bmem_read), 256'(1));
      check_eq({tag, "_bmem_addr"}, 256'(bmem_addr), 256'(a));
      check_eq({tag, "_busy_ready"}, 256'(ufp_ready), 256'(0));
      cyc();
      #1;
      check_eq({tag, "_read_hold"}, 256'(bmem_read), 256'(1));
      bmem_ready = 1'b1;
      cyc();
      bmem_ready = 1'b0;
      #1;
      check_eq({tag, "_read_drop"}, 256'(bmem_read), 256'(0));
      bi = 0;
      for (int s = 0; s < (stray ? 5 : 4); s++) begin
         if (stray && s == 1) begin
            bmem_raddr = 32'h1EC0_00A0;
            bmem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
         end else begin
            bmem_raddr = a;
            bmem_rdata = mk_beat(bi, base);
            bi++;
         end
         bmem_rvalid = 1'b1;
         #1;
         check_eq({tag, "_early_rvalid"}, 256'(ufp_rvalid), 256'(0));
         cyc();
      end
      bmem_rvalid = 1'b0;
      #1;
      check_eq({tag, "_rvalid"}, 256'(ufp_rvalid), 256'(1));
      check_eq({tag, "_rdata"}, ufp_rdata, exp);
      check_eq({tag, "_raddr"}, 256'(ufp_raddr), 256'(a));
      cyc();
      #1;
      check_eq({tag, "_rvalid_pulse"}, 256'(ufp_rvalid), 256'(0));
      check_eq({tag, "_ready_back"}, 256'(ufp_ready), 256'(1));
   endtask

`ifndef CACHELINE_ADAPTER_WBUF_EN
   // Issue a blocking write and serve its beats with the given ready pattern.
   task automatic write_line(input logic [31:0] a, input logic [255:0] d,
                             input logic [7:0] pat, input int len, input string tag);
      int bi;
      ufp_addr  = a;
      ufp_wdata = d;
      ufp_write = 1'b1;
      #1;
      check_eq({tag, "_ready"}, 256'(ufp_ready), 256'(1));
      cyc();
      ufp_write = 1'b0;
      bi = 0;
      for (int k = 0; k < len; k++) begin
         bmem_ready = pat[k];
         #1;
         check_eq({tag, "_bmem_write"}, 256'(bmem_write), 256'(1));
         check_eq({tag, "_wdata"}, 256'(bmem_wdata), 256'(d[64*bi +: 64]));
         check_eq({tag, "_waddr"}, 256'(bmem_addr), 256'(a));
         check_eq({tag, "_busy_ready"}, 256'(ufp_ready), 256'(0));
         if (pat[k]) bi++;
         cyc();
      end
      bmem_ready = 1'b0;
      #1;
      check_eq({tag, "_write_done"}, 256'(bmem_write), 256'(0));
      check_eq({tag, "_ready_back"}, 256'(ufp_ready), 256'(1));
   endtask
`endif

   initial begin
      logic [255:0] wline;
      rst         = 1'b0;
      ufp_addr    = '0;
      ufp_read    = 1'b0;
      ufp_write   = 1'b0;
      ufp_wdata   = '0;
      bmem_ready  = 1'b0;
      bmem_raddr  = '0;
      bmem_rdata  = '0;
      bmem_rvalid = 1'b0;

      // Reset state
      cyc();
      cyc();
      ufp_read = 1'b1;
      #1;
      check_eq("rst_ready", 256'(ufp_ready), 256'(0));
      check_eq("rst_rvalid", 256'(ufp_rvalid), 256'(0));
      check_eq("rst_bmem_read", 256'(bmem_read), 256'(0));
      check_eq("rst_bmem_write", 256'(bmem_write), 256'(0));
      ufp_read = 1'b0;
      cyc();
      rst = 1'b1;
      #1;
      check_eq("idle_ready", 256'(ufp_ready), 256'(1));

      // Plain read of 0x1EC0_0040
      rd_accept(32'h1EC0_0040, "rd1");
      rd_complete(32'h1EC0_0040, 64'h0, 1'b0, "rd1");

      // Read with a stray beat in the middle of the burst
      rd_accept(32'h1EC0_0040, "rd_stray");
      rd_complete(32'h1EC0_0040, 64'h0F0F_0000_A5A5_0001, 1'b1, "rd_stray");

`ifndef CACHELINE_ADAPTER_WBUF_EN
      // Write with bmem_ready pattern 1,0,1,1,0,1
      for (int i = 0; i < 4; i++) wline[64*i +: 64] = mk_beat(i, 64'h0123_4567_89AB_CDEF);
      write_line(32'h1EC0_0080, wline, 8'b0010_1101, 6, "wr1");

      // Read and write together: write burst first, then the held read
      for (int i = 0; i < 4; i++) wline[64*i +: 64] = mk_beat(i, 64'hFEDC_BA98_7654_3210);
      ufp_read = 1'b1;
      write_line(32'h1EC0_00C0, wline, 8'b0000_1111, 4, "rw_wr");
      rd_accept(32'h1EC0_00C0, "rw_rd");
      rd_complete(32'h1EC0_00C0, 64'h5555_0000_3333_0000, 1'b0, "rw_rd");
`else
      // Posted write to 0x100, drain held off by bmem_ready=0
      for (int i = 0; i < 4; i++) wline[64*i +: 64] = mk_beat(i, 64'h0123_4567_89AB_CDEF);
      ufp_addr  = 32'h0000_0100;
      ufp_wdata = wline;
      ufp_write = 1'b1;
      #1;
      check_eq("wb_ready", 256'(ufp_ready), 256'(1));
      cyc();
      #1;
      check_eq("wb_ready_next", 256'(ufp_ready), 256'(0));
      ufp_write = 1'b0;
      #1;
      check_eq("wb_ready_idle", 256'(ufp_ready), 256'(1));
      check_eq("wb_drain_write", 256'(bmem_write), 256'(1));
      // Read hit on the buffered line
      ufp_read = 1'b1;
      cyc();
      ufp_read = 1'b0;
      #1;
      check_eq("wb_hit_no_read", 256'(bmem_read), 256'(0));
      check_eq("wb_hit_early", 256'(ufp_rvalid), 256'(0));
      cyc();
      #1;
      check_eq("wb_hit_rvalid", 256'(ufp_rvalid), 256'(1));
      check_eq("wb_hit_rdata", ufp_rdata, wline);
      check_eq("wb_hit_raddr", 256'(ufp_raddr), 256'(32'h0000_0100));
      check_eq("wb_hit_no_read2", 256'(bmem_read), 256'(0));
      cyc();
      // Miss read waits for the drain
      rd_accept(32'h0000_0200, "wb_miss");
      for (int i = 0; i < 4; i++) begin
         bmem_ready = 1'b1;
         #1;
         check_eq("wb_drain_beat", 256'(bmem_write), 256'(1));
         check_eq("wb_drain_data", 256'(bmem_wdata), 256'(wline[64*i +: 64]));
         check_eq("wb_drain_addr", 256'(bmem_addr), 256'(32'h0000_0100));
         check_eq("wb_miss_wait", 256'(bmem_read), 256'(0));
         cyc();
      end
      bmem_ready = 1'b0;
      #1;
      check_eq("wb_drained", 256'(bmem_write), 256'(0));
      rd_complete(32'h0000_0200, 64'h7777_0000_0000_1234, 1'b0, "wb_miss");
`endif

      // Reset after the second read beat, then two late beats
      rd_accept(32'h1EC0_0100, "rst_mid");
      bmem_ready = 1'b1;
      cyc();
      bmem_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bmem_raddr  = 32'h1EC0_0100;
         bmem_rdata  = mk_beat(i, 64'h0);
         bmem_rvalid = 1'b1;
         cyc();
      end
      bmem_rvalid = 1'b0;
      rst = 1'b0;
      #1;
      check_eq("rst_mid_ready", 256'(ufp_ready), 256'(0));
      check_eq("rst_mid_bmem_read", 256'(bmem_read), 256'(0));
      cyc();
      rst = 1'b1;
      #1;
      check_eq("rst_mid_ready_after", 256'(ufp_ready), 256'(1));
      for (int i = 2; i < 4; i++) begin
         bmem_raddr  = 32'h1EC0_0100;
         bmem_rdata  = mk_beat(i, 64'h0);
         bmem_rvalid = 1'b1;
         #1;
         check_eq("rst_mid_late_rvalid", 256'(ufp_rvalid), 256'(0));
         cyc();
      end
      bmem_rvalid = 1'b0;
      #1;
      check_eq("rst_mid_no_resp", 256'(ufp_rvalid), 256'(0));
      check_eq("rst_mid_idle_read", 256'(bmem_read), 256'(0));
      cyc();

      // Fresh read after the abandoned burst
      rd_accept(32'h1EC0_0140, "rd_after_rst");
      rd_complete(32'h1EC0_0140, 64'hABCD_0000_0000_9876, 1'b0, "rd_after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cacheline_adapter.md
Name: cacheline_adapter

Overview:
- Memory-side responder for the cacheline interface: services 256-bit cacheline read/write requests from the icache/dcache arbiter.
- Translates each request into a 4-beat, 64-bit burst on the banked burst memory (bmem) port.
- Read beats are assembled into one cacheline response; write lines are split into beats.
- Sits between the cache arbiter and bmem; one request in flight at a time.

Parameters:
- BEATS, 4, burst length per cacheline.
- BEAT_W, 64, bmem data width; line width = BEATS*BEAT_W = 256.
- OFFSET_IDX, 5, byte-offset bits of a line address; forced to zero on bmem_addr.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-low (low = reset).
- ufp_addr  in  32  line address.
- ufp_read  in  1  read request.
- ufp_write  in  1  write request.
- ufp_wdata  in  256  write line.
- ufp_ready  out  1  request accepted on a cycle with ready & (read|write).
- ufp_raddr  out  32  line address of the returned line.
- ufp_rdata  out  256  returned line.
- ufp_rvalid  out  1  one-cycle read response strobe.
- bmem_addr  out  32  burst address, bits [4:0]=0.
- bmem_read  out  1  burst read command.
- bmem_write  out  1  write beat valid.
- bmem_wdata  out  64  write beat data.
- bmem_ready  in  1  bmem accepts command or beat this cycle.
- bmem_raddr  in  32  address tag of a returned beat.
- bmem_rdata  in  64  returned beat data.
- bmem_rvalid  in  1  returned beat valid.

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; beat counter 0.
  - Outputs: ufp_ready=0, ufp_rvalid=0, bmem_read=0, bmem_write=0.
  - Data/address outputs are don't-care.
  - Reset mid-burst abandons the burst. Beats arriving after reset are ignored.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, RD_RESP, WR_BEAT.
- IDLE: ufp_ready=1.
  - write accepted: latch addr/wdata, go to WR_BEAT, cnt=0.
  - else read accepted: latch addr, go to RD_ISSUE.
  - read and write together: write wins; read stays pending (requester holds it).
- RD_ISSUE: bmem_read=1 and bmem_addr = latched addr with [4:0]=0, held until bmem_ready=1, then go to RD_WAIT, cnt=0.
- RD_WAIT: on bmem_rvalid with bmem_raddr equal to the latched line address, store beat at bits [64*cnt +: 64] and increment cnt.
  - Beats with a mismatching raddr are dropped.
  - The 4th matching beat (cnt==3) sends the FSM to RD_RESP.
- RD_RESP: for exactly 1 cycle, ufp_rvalid=1, ufp_rdata = assembled line, ufp_raddr = latched addr; then IDLE.
  - Read latency = bmem latency + 2 cycles minimum.
- WR_BEAT: bmem_write=1, bmem_addr = line address, bmem_wdata = wdata[64*cnt +: 64].
  - cnt advances only when bmem_ready=1.
  - After beat 3 is accepted, go to IDLE. Writes are posted: no ufp response.
- ufp_ready=0 in every state other than IDLE.
- Counter is 2 bits; it wraps 3→0 only on state exit.

Optional Feature:
- Macro CACHELINE_ADAPTER_WBUF_EN adds a one-line posted write buffer.
- Defined:
  - A write accepted in IDLE is copied into the buffer; ufp_ready stays 1 the next cycle.
  - A drain engine issues the 4 write beats in the background.
  - A second write is not accepted (ready=0 while a write is presented) until the buffer is empty.
  - A read whose line address matches the buffered line returns the buffered data via RD_RESP one cycle after acceptance, with no bmem traffic.
  - A non-matching read waits in RD_ISSUE until the drain completes.
- Undefined: the behaviour is exactly as in Behaviour above (blocking writes).

Decomposition:
- Package cacheline_adapter_types holds:
  - enum adapter_state_t {IDLE, RD_ISSUE, RD_WAIT, RD_RESP, WR_BEAT};
  - localparams BEATS, BEAT_W, LINE_W;
  - beat_cnt_t (2 bits).
- One natural sub-module, cacheline_beat_assembler: the beat counter and line register used for read assembly and write slicing.

Test Plan:
- Read 0x1EC0_0040, bmem returns 4 beats 0x11..,0x22..,0x33..,0x44.. → one ufp_rvalid pulse; rdata[63:0]=0x11.., rdata[255:192]=0x44..; raddr=0x1EC0_0040.
- Write 0x1EC0_0080 with bmem_ready toggling 1,0,1,1,0,1 → exactly 4 bmem_write beats, each accepted in order with the correct 64-bit slice; ufp_ready returns to 1 afterwards.
- In RD_WAIT, inject a beat with raddr 0x1EC0_00A0 among valid beats → stray beat dropped; returned line is unaffected.
- ufp_read=ufp_write=1 in IDLE → write burst first; the held read completes afterwards.
- rst=0 after the 2nd read beat, then 2 late beats → no ufp_rvalid; ufp_ready=1 the cycle after reset deasserts.
- WBUF_EN: write 0x100 then read 0x100 → rvalid 2 cycles after the read is accepted with the written data and no bmem_read; then read 0x200 → bmem_read only after the 4th drain beat.
